// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and sizes for the 4-way round-robin arbiter.
//   state_t : arbiter FSM states (IDLE, GRANT)
//   NREQ    : number of requesters
//   IDX_W   : width of an encoded requester index
package rr_arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/dec2to4.sv
// dec2to4: 2-to-4 one-hot decoder with enable.
//   en : when low, y is all zeros
//   a  : 2-bit select
//   y  : one-hot decode of a, gated by en
module dec2to4 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] y
);

  // One-hot decode of the select, forced to zero when disabled.
  always_comb begin
    y = 4'b0000;
    if (en) begin
      case (a)
        2'd0:    y = 4'b0001;
        2'd1:    y = 4'b0010;
        2'd2:    y = 4'b0100;
        2'd3:    y = 4'b1000;
        default: y = 4'b0000;
      endcase
    end else begin
      y = 4'b0000;
    end
  end

endmodule

// File: rtl/rr_pick4.sv
// rr_pick4: combinational rotate-priority picker.
//   req : request vector
//   ptr : requester with highest priority; priority falls off upward with wrap 3->0
//   any : at least one request is set
//   idx : first set request found scanning from ptr (equals ptr when any=0)
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic             any_s;
  logic [IDX_W-1:0] idx_s;

  // Scan ptr, ptr+1, ... (mod 4) and keep the first requester that is set.
  always_comb begin
    logic [IDX_W-1:0] cand;
    any_s = 1'b0;
    idx_s = ptr;
    cand  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!any_s && req[cand]) begin
        any_s = 1'b1;
        idx_s = cand;
      end else begin
        any_s = any_s;
      end
    end
  end

  assign any = any_s;
  assign idx = idx_s;

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: round-robin arbiter for one 4-slot resource with one-hot select.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   req     : request vector, bit i = requester i
//   rel     : release pulses; only the current owner's bit is honoured
//   gnt     : one-hot grant, zero when no grant is active
//   gnt_idx : encoded owner, keeps the last owner while gnt_vld=0
//   gnt_vld : a grant is active
//   timeout : one-cycle pulse when a grant is revoked by the hold limit
// A grant always ends with at least one IDLE cycle before the next owner is picked.
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  rel,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_r,    state_nxt_s;
  logic [IDX_W-1:0] ptr_r,      ptr_nxt_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
  logic [IDX_W-1:0] gnt_idx_r,  gnt_idx_nxt_s;
  logic             gnt_vld_r,  gnt_vld_nxt_s;
  logic             timeout_r,  timeout_nxt_s;

  logic             pick_any_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             rel_hit_s;
  logic             req_drop_s;
  logic             hold_hit_s;
  logic             exit_s;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Owner-side exit causes; a release or request drop takes precedence over the limit.
  assign rel_hit_s  = rel[gnt_idx_r];
  assign req_drop_s = ~req[gnt_idx_r];
  assign hold_hit_s = (hold_cnt_r == HOLD_LAST);
  assign exit_s     = rel_hit_s | req_drop_s | hold_hit_s;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= {IDX_W{1'b0}};
      hold_cnt_r <= {CNT_W{1'b0}};
      gnt_idx_r  <= {IDX_W{1'b0}};
      gnt_vld_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      gnt_idx_r  <= gnt_idx_nxt_s;
      gnt_vld_r  <= gnt_vld_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (exit_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    ptr_nxt_s      = ptr_r;
    hold_cnt_nxt_s = hold_cnt_r;
    gnt_idx_nxt_s  = gnt_idx_r;
    gnt_vld_nxt_s  = gnt_vld_r;
    timeout_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          gnt_idx_nxt_s  = pick_idx_s;
          gnt_vld_nxt_s  = 1'b1;
          hold_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          gnt_vld_nxt_s  = 1'b0;
        end
      end
      GRANT: begin
        if (exit_s) begin
          gnt_vld_nxt_s  = 1'b0;
          ptr_nxt_s      = gnt_idx_r + 2'd1;
          hold_cnt_nxt_s = {CNT_W{1'b0}};
          timeout_nxt_s  = hold_hit_s & ~rel_hit_s & ~req_drop_s;
        end else begin
          gnt_vld_nxt_s  = 1'b1;
          if (hold_cnt_r < HOLD_LAST) begin
            hold_cnt_nxt_s = hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            hold_cnt_nxt_s = hold_cnt_r;
          end
        end
      end
      default: begin
        gnt_vld_nxt_s = 1'b0;
      end
    endcase
  end

  // gnt is a pure decode of the registered owner, so it can never be multi-hot.
  dec2to4 u_dec (
    .en (gnt_vld_r),
    .a  (gnt_idx_r),
    .y  (gnt)
  );

  assign gnt_idx = gnt_idx_r;
  assign gnt_vld = gnt_vld_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: scoreboard bench for rr_arbiter4 (MAX_HOLD=16).
// Each scenario queues per-cycle stimulus together with the expected outputs
// {gnt, gnt_idx, gnt_vld, timeout} after the following clock edge, then drains
// the queues one cycle at a time and compares.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] rel;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int n_tests;
  int n_fail;

  typedef struct packed {
    logic       r;
    logic [3:0] q;
    logic [3:0] l;
  } stim_t;

  stim_t      stim_q[$];
  logic [7:0] sb[$];

  rr_arbiter4 #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ex(input logic [3:0] g, input logic [1:0] i,
                                    input logic v, input logic t);
    return {g, i, v, t};
  endfunction

  function automatic logic [7:0] outs();
    return {gnt, gnt_idx, gnt_vld, timeout};
  endfunction

  task automatic push(input logic r, input logic [3:0] q, input logic [3:0] l,
                      input logic [7:0] e);
    stim_t s;
    s.r = r; s.q = q; s.l = l;
    stim_q.push_back(s);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    stim_t s; logic [7:0] e; int step;
    push(1'b1, 4'b0000, 4'b0000, ex(4'b0000, 2'd0, 1'b0, 1'b0));
    push(1'b1, 4'b1111, 4'b0000, ex(4'b0000, 2'd0, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) push(1'b0, 4'b0000, 4'b0000, ex(4'b0000, 2'd0, 1'b0, 1'b0));
    step = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); rst = s.r; req = s.q; rel = s.l;
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL reset step %0d: got %b want %b", step, outs(), e);
      end
      step++;
    end
  endtask

  task automatic test_basic();
    stim_t s; logic [7:0] e; int step;
    push(1'b0, 4'b1010, 4'b0000, ex(4'b0010, 2'd1, 1'b1, 1'b0));
    push(1'b0, 4'b1010, 4'b0010, ex(4'b0000, 2'd1, 1'b0, 1'b0));
    push(1'b0, 4'b1010, 4'b0000, ex(4'b1000, 2'd3, 1'b1, 1'b0));
    push(1'b0, 4'b0000, 4'b0000, ex(4'b0000, 2'd3, 1'b0, 1'b0));
    push(1'b0, 4'b0000, 4'b0000, ex(4'b0000, 2'd3, 1'b0, 1'b0));
    step = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); rst = s.r; req = s.q; rel = s.l;
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL basic step %0d: got %b want %b", step, outs(), e);
      end
      step++;
    end
  endtask

  task automatic test_rotation();
    stim_t s; logic [7:0] e; int step; int k; logic [3:0] oh;
    for (int n = 0; n < 5; n++) begin
      k = n % 4;
      oh = 4'b0001 << k;
      push(1'b0, 4'b1111, 4'b0000, ex(oh, 2'(k), 1'b1, 1'b0));
      push(1'b0, 4'b1111, 4'b0000, ex(oh, 2'(k), 1'b1, 1'b0));
      push(1'b0, 4'b1111, oh,      ex(4'b0000, 2'(k), 1'b0, 1'b0));
    end
    push(1'b0, 4'b0000, 4'b0000, ex(4'b0000, 2'd0, 1'b0, 1'b0));
    step = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); rst = s.r; req = s.q; rel = s.l;
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL rotation step %0d: got %b want %b", step, outs(), e);
      end
      step++;
    end
  endtask

  task automatic test_timeout();
    stim_t s; logic [7:0] e; int step;
    for (int i = 0; i < 16; i++) push(1'b0, 4'b0100, 4'b0000, ex(4'b0100, 2'd2, 1'b1, 1'b0));
    push(1'b0, 4'b0100, 4'b0000, ex(4'b0000, 2'd2, 1'b0, 1'b1));
    push(1'b0, 4'b0100, 4'b0000, ex(4'b0100, 2'd2, 1'b1, 1'b0));
    push(1'b0, 4'b0000, 4'b0000, ex(4'b0000, 2'd2, 1'b0, 1'b0));
    step = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); rst = s.r; req = s.q; rel = s.l;
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL timeout step %0d: got %b want %b", step, outs(), e);
      end
      step++;
    end
  endtask

  task automatic test_nonowner_rel();
    stim_t s; logic [7:0] e; int step;
    push(1'b0, 4'b0010, 4'b0000, ex(4'b0010, 2'd1, 1'b1, 1'b0));
    push(1'b0, 4'b0010, 4'b0001, ex(4'b0010, 2'd1, 1'b1, 1'b0));
    push(1'b0, 4'b0010, 4'b1101, ex(4'b0010, 2'd1, 1'b1, 1'b0));
    push(1'b0, 4'b0000, 4'b0000, ex(4'b0000, 2'd1, 1'b0, 1'b0));
    push(1'b0, 4'b0000, 4'b1111, ex(4'b0000, 2'd1, 1'b0, 1'b0));
    step = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); rst = s.r; req = s.q; rel = s.l;
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL nonowner_rel step %0d: got %b want %b", step, outs(), e);
      end
      step++;
    end
  endtask

  task automatic test_reset_mid();
    stim_t s; logic [7:0] e; int step;
    push(1'b0, 4'b1000, 4'b0000, ex(4'b1000, 2'd3, 1'b1, 1'b0));
    push(1'b0, 4'b1000, 4'b0000, ex(4'b1000, 2'd3, 1'b1, 1'b0));
    push(1'b1, 4'b1000, 4'b0000, ex(4'b0000, 2'd0, 1'b0, 1'b0));
    push(1'b0, 4'b1001, 4'b0000, ex(4'b0001, 2'd0, 1'b1, 1'b0));
    push(1'b0, 4'b0000, 4'b0000, ex(4'b0000, 2'd0, 1'b0, 1'b0));
    step = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); rst = s.r; req = s.q; rel = s.l;
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: got %b want %b", step, outs(), e);
      end
      step++;
    end
  endtask

  task automatic test_limit_with_rel();
    stim_t s; logic [7:0] e; int step;
    for (int i = 0; i < 16; i++) push(1'b0, 4'b0010, 4'b0000, ex(4'b0010, 2'd1, 1'b1, 1'b0));
    push(1'b0, 4'b0010, 4'b0010, ex(4'b0000, 2'd1, 1'b0, 1'b0));
    push(1'b0, 4'b0000, 4'b0000, ex(4'b0000, 2'd1, 1'b0, 1'b0));
    step = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); rst = s.r; req = s.q; rel = s.l;
      @(posedge clk); #1;
      e = sb.pop_front(); n_tests++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL limit_with_rel step %0d: got %b want %b", step, outs(), e);
      end
      step++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    req = 4'b0000;
    rel = 4'b0000;
    test_reset();
    test_basic();
    test_rotation();
    test_timeout();
    test_nonowner_rel();
    test_reset_mid();
    test_limit_with_rel();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
